scan_mux_n: RTL

- Parametrised N-channel, WIDTH-bit registered multiplexer. It is the sequential successor to the 2:1 mux cell.
- Channel select is either loaded explicitly or advanced by an internal scanner with a programmable prescaler, up or down.
- Sits between the serial/shift channels and the output pad: one channel drives dout at a time, with a one-cycle registered output.

---
 rtl/scan_mux_pkg.sv | 38 +++
 rtl/mux2.sv | 13 +
 rtl/mux_tree_n.sv | 37 +++
 rtl/scan_mux_n.sv | 98 +++++++++
 4 files changed

// File: rtl/scan_mux_pkg.sv
// rtl/scan_mux_pkg.sv - mode encodings and scanner next-select helper for scan_mux_n
package scan_mux_pkg;

  localparam logic [1:0] MODE_MANUAL  = 2'b00;
  localparam logic [1:0] MODE_SCAN_UP = 2'b01;
  localparam logic [1:0] MODE_SCAN_DN = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  // wrap sits in the LSB so callers can size-cast the result down to SEL_W+1 bits
  typedef struct packed {
    logic [7:0] sel;
    logic       wrap;
  } sel_step_t;

  function automatic sel_step_t next_sel(input logic [7:0] sel,
                                         input logic [7:0] last,
                                         input logic       down);
    sel_step_t r;
    r.wrap = 1'b0;
    if (down) begin
      if (sel == 8'd0) begin
        r.sel  = last;
        r.wrap = 1'b1;
      end else begin
        r.sel = sel - 8'd1;
      end
    end else begin
      if (sel == last) begin
        r.sel  = 8'd0;
        r.wrap = 1'b1;
      end else begin
        r.sel = sel + 8'd1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/mux2.sv
// rtl/mux2.sv - WIDTH-bit 2:1 mux cell
module mux2 #(
  parameter int WIDTH = 1
) (
  input  logic [WIDTH-1:0] d0_i,
  input  logic [WIDTH-1:0] d1_i,
  input  logic             s_i,
  output logic [WIDTH-1:0] y_o
);

  assign y_o = s_i ? d1_i : d0_i;

endmodule

// File: rtl/mux_tree_n.sv
// rtl/mux_tree_n.sv - balanced combinational tree of mux2 cells, sel LSB at the leaves
module mux_tree_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS*WIDTH-1:0] din_i,
  input  logic [SEL_W-1:0]          sel_i,
  output logic [WIDTH-1:0]          dout_o
);

  localparam int LEAVES = 1 << SEL_W;

  // Heap layout: node 1 is the root, nodes LEAVES.. are the channel leaves.
  logic [WIDTH-1:0] node [1:2*LEAVES-1];

  genvar g;
  for (g = 0; g < LEAVES; g++) begin : g_leaf
    if (g < CHANNELS) begin : g_real
      assign node[LEAVES+g] = din_i[g*WIDTH +: WIDTH];
    end else begin : g_pad
      assign node[LEAVES+g] = '0;
    end
  end

  for (g = 1; g < LEAVES; g++) begin : g_stage
    mux2 #(.WIDTH(WIDTH)) u_mux2 (
      .d0_i (node[2*g]),
      .d1_i (node[2*g+1]),
      .s_i  (sel_i[SEL_W-$clog2(g+1)]),
      .y_o  (node[g])
    );
  end

  assign dout_o = node[1];

endmodule

// File: rtl/scan_mux_n.sv
// rtl/scan_mux_n.sv - N-channel registered mux with manual load and prescaled up/down scanner
module scan_mux_n #(
  parameter int WIDTH    = 1,
  parameter int CHANNELS = 8,
  parameter int SEL_W    = $clog2(CHANNELS),
  parameter int DIV_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS*WIDTH-1:0] din,
  input  logic [1:0]                mode,
  input  logic [SEL_W-1:0]          sel_in,
  input  logic                      sel_load,
  input  logic [DIV_W-1:0]          div,
  output logic [WIDTH-1:0]          dout,
  output logic [SEL_W-1:0]          cur_sel,
  output logic                      wrap,
  output logic                      sel_err
);
  import scan_mux_pkg::*;

  localparam logic [SEL_W:0] CH_L  = (SEL_W+1)'(CHANNELS);
  localparam logic [7:0]     LAST8 = 8'(CHANNELS - 1);

  logic [SEL_W-1:0] sel_q, sel_d;
  logic [DIV_W-1:0] pre_q, pre_d;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] dout_q, dout_d, tree_out;
  logic             wrap_q, wrap_d;
  logic             err_q, err_d;

  logic             hold, mode_chg, load_ok, load_valid, adv;
  logic [SEL_W-1:0] step_sel;
  logic             step_wrap;

  mux_tree_n #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .SEL_W(SEL_W)) u_tree (
    .din_i  (din),
    .sel_i  (sel_q),
    .dout_o (tree_out)
  );

  always_comb begin
    hold       = (mode == MODE_HOLD);
    mode_chg   = (mode != mode_q);
    load_ok    = sel_load && !hold;
    load_valid = load_ok && ({1'b0, sel_in} < CH_L);
    // a honoured load pre-empts the scanner, even when the value is rejected
    adv        = ((mode == MODE_SCAN_UP) || (mode == MODE_SCAN_DN)) && !mode_chg &&
                 !load_ok && (pre_q == div);
    {step_sel, step_wrap} = (SEL_W+1)'(next_sel(8'(sel_q), LAST8, mode == MODE_SCAN_DN));

    sel_d  = sel_q;
    wrap_d = 1'b0;
    if (load_valid) begin
      sel_d = sel_in;
    end else if (adv) begin
      sel_d  = step_sel;
      wrap_d = step_wrap;
    end

    if (mode_chg || load_valid || (mode == MODE_MANUAL)) begin
      pre_d = '0;
    end else if (hold) begin
      pre_d = pre_q;
    end else if (pre_q == div) begin
      pre_d = '0;
    end else begin
      pre_d = pre_q + DIV_W'(1);
    end

    err_d  = err_q | (load_ok && !load_valid);
    dout_d = hold ? dout_q : tree_out;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q  <= '0;
      pre_q  <= '0;
      mode_q <= MODE_MANUAL;
      dout_q <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      pre_q  <= pre_d;
      mode_q <= mode;
      dout_q <= dout_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign dout    = dout_q;
  assign cur_sel = sel_q;
  assign wrap    = wrap_q;
  assign sel_err = err_q;

endmodule
